// File: rtl/uart_rx_fifo_param_pkg.sv
// Shared types and constants for the parametrised UART receive path.
// The state encoding is fixed and test benches rely on these values.
package uart_rx_fifo_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-cycle tick every DVSR clocks.
module uart_baud_gen #(
    parameter int DVSR = 163
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W    = $clog2(DVSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVSR - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_fifo_param_rx.sv
// Oversampled receiver FSM with input synchroniser, optional parity and stop-bit check.
// current_state and s keep these names so benches can probe them hierarchically.
module uart_rx_fifo_param_rx
    import uart_rx_fifo_param_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_i,
    input  logic            tick_i,
    output logic            push_o,
    output logic            ferr_o,
    output logic            pbad_o,
    output logic [DBIT-1:0] data_o
);

    localparam int S_W = $clog2(max_int(OS, SB_TICK));
    localparam int N_W = $clog2(DBIT);

    localparam logic [S_W-1:0] S_START_LAST = S_W'(OS / 2 - 1);
    localparam logic [S_W-1:0] S_BIT_LAST   = S_W'(OS - 1);
    localparam logic [S_W-1:0] S_STOP_LAST  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST       = N_W'(DBIT - 1);
    localparam logic           ODD_MODE     = (PARITY == PAR_ODD);

    logic [1:0]      sync_q;
    logic            rx;
    rx_state_e       current_state;
    logic [S_W-1:0]  s;
    logic [N_W-1:0]  n_q;
    logic [DBIT-1:0] b_q;
    logic            p_bad_q;
    logic            stop_sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx = sync_q[1];

    // Start detection is not tick-gated; the START state then re-samples at mid-bit to reject glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_state <= ST_IDLE;
            s             <= '0;
            n_q           <= '0;
            b_q           <= '0;
            p_bad_q       <= 1'b0;
        end else begin
            case (current_state)
                ST_IDLE: begin
                    if (!rx) begin
                        current_state <= ST_START;
                        s             <= '0;
                    end
                end
                ST_START: begin
                    if (tick_i) begin
                        if (s == S_START_LAST) begin
                            s <= '0;
                            if (!rx) begin
                                current_state <= ST_DATA;
                                n_q           <= '0;
                                p_bad_q       <= 1'b0;
                            end else begin
                                current_state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_i) begin
                        if (s == S_BIT_LAST) begin
                            s   <= '0;
                            b_q <= {rx, b_q[DBIT-1:1]};
                            if (n_q == N_LAST) begin
                                current_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                n_q <= n_q + N_W'(1);
                            end
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_i) begin
                        if (s == S_BIT_LAST) begin
                            s             <= '0;
                            p_bad_q       <= (((^b_q) ^ rx) != ODD_MODE);
                            current_state <= ST_STOP;
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_i) begin
                        if (s == S_STOP_LAST) begin
                            s             <= '0;
                            current_state <= ST_IDLE;
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                default: begin
                    current_state <= ST_IDLE;
                    s             <= '0;
                end
            endcase
        end
    end

    // The frame verdict is issued on the stop sample tick so the FIFO can act on the same edge.
    assign stop_sample = (current_state == ST_STOP) && tick_i && (s == S_STOP_LAST);
    assign push_o      = stop_sample & rx;
    assign ferr_o      = stop_sample & ~rx;
    assign pbad_o      = p_bad_q;
    assign data_o      = b_q;

endmodule

// File: rtl/uart_rx_fifo_param.sv
// UART receive path: baud tick generator, oversampled receiver and a first-word
// fall-through RX FIFO with sticky framing, parity and overflow flags.
module uart_rx_fifo_param
    import uart_rx_fifo_param_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int PARITY  = 0,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_rx,
    input  logic            rd,
    input  logic            clr_err,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overflow
);

    localparam int DEPTH = 2 ** FIFO_W;

    logic            tick;
    logic            rx_push;
    logic            rx_ferr;
    logic            rx_pbad;
    logic [DBIT-1:0] rx_word;

    uart_baud_gen #(
        .DVSR(DVSR)
    ) baud (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    uart_rx_fifo_param_rx #(
        .DBIT   (DBIT),
        .OS     (OS),
        .SB_TICK(SB_TICK),
        .PARITY (PARITY)
    ) receptor (
        .clk   (clk),
        .reset (reset),
        .rx_i  (i_rx),
        .tick_i(tick),
        .push_o(rx_push),
        .ferr_o(rx_ferr),
        .pbad_o(rx_pbad),
        .data_o(rx_word)
    );

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic              full_q, full_d, empty_q, empty_d;
    logic              rd_en, wr_en, drop;

    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    assign rd_en      = rd & ~empty_q;
    assign wr_en      = rx_push & (~full_q | rd_en);
    assign drop       = rx_push & full_q & ~rd_en;
    assign wr_ptr_inc = wr_ptr_q + FIFO_W'(1);
    assign rd_ptr_inc = rd_ptr_q + FIFO_W'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        case ({wr_en, rd_en})
            2'b01: begin
                rd_ptr_d = rd_ptr_inc;
                full_d   = 1'b0;
                empty_d  = (rd_ptr_inc == wr_ptr_q);
            end
            2'b10: begin
                wr_ptr_d = wr_ptr_inc;
                empty_d  = 1'b0;
                full_d   = (wr_ptr_inc == rd_ptr_q);
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_inc;
                rd_ptr_d = rd_ptr_inc;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= rx_word;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign r_data   = mem_q[rd_ptr_q];
    assign rx_empty = empty_q;
    assign rx_full  = full_q;

    logic frame_err_q, frame_err_d;
    logic parity_err_q, parity_err_d;
    logic overflow_q, overflow_d;

    // Sticky flags are set-dominant: a new error wins over a simultaneous clear.
    always_comb begin
        frame_err_d  = rx_ferr | (frame_err_q & ~clr_err);
        parity_err_d = (rx_push & rx_pbad) | (parity_err_q & ~clr_err);
        overflow_d   = drop | (overflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param: serial frames are driven on the line, expected
// words go into a scoreboard queue and are compared as they are popped from the FIFO.
module tb_uart_rx_fifo_param;
    import uart_rx_fifo_param_pkg::*;

    localparam int DBIT     = 8;
    localparam int OS       = 16;
    localparam int SB_TICK  = 16;
    localparam int DVSR     = 4;
    localparam int FIFO_W   = 2;
    localparam int BIT_CLKS = OS * DVSR;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       rxLine  = 1'b1;
    logic       rxLineP = 1'b1;
    logic       rd      = 1'b0;
    logic       rdP     = 1'b0;
    logic       clrErr  = 1'b0;
    logic       clrErrP = 1'b0;
    logic [7:0] rData, rDataP;
    logic       rxEmpty, rxFull, frameErr, parityErr, overflow;
    logic       rxEmptyP, rxFullP, frameErrP, parityErrP, overflowP;

    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] expQ[$];
    bit         found;

    always #5 clk = ~clk;

    uart_rx_fifo_param #(
        .DBIT(DBIT), .OS(OS), .SB_TICK(SB_TICK), .DVSR(DVSR), .PARITY(0), .FIFO_W(FIFO_W)
    ) dut (
        .clk(clk), .reset(reset), .i_rx(rxLine), .rd(rd), .clr_err(clrErr),
        .r_data(rData), .rx_empty(rxEmpty), .rx_full(rxFull),
        .frame_err(frameErr), .parity_err(parityErr), .overflow(overflow)
    );

    uart_rx_fifo_param #(
        .DBIT(DBIT), .OS(OS), .SB_TICK(SB_TICK), .DVSR(DVSR), .PARITY(1), .FIFO_W(FIFO_W)
    ) dutP (
        .clk(clk), .reset(reset), .i_rx(rxLineP), .rd(rdP), .clr_err(clrErrP),
        .r_data(rDataP), .rx_empty(rxEmptyP), .rx_full(rxFullP),
        .frame_err(frameErrP), .parity_err(parityErrP), .overflow(overflowP)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setLine(input bit par, input logic v);
        if (par) rxLineP = v;
        else     rxLine  = v;
    endtask

    task automatic sendHead(input bit par, input logic [7:0] data, input bit withPar, input logic parBit);
        setLine(par, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < DBIT; i++) begin
            setLine(par, data[i]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (withPar) begin
            setLine(par, parBit);
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    // A low stop bit is cut short so the trailing low half-bit is rejected as a glitch.
    task automatic applyStimulus(input bit par, input logic [7:0] data, input bit withPar,
                                 input logic parBit, input logic stopBit);
        sendHead(par, data, withPar, parBit);
        setLine(par, stopBit);
        repeat (stopBit ? BIT_CLKS : 44) @(negedge clk);
        setLine(par, 1'b1);
        repeat (48) @(negedge clk);
    endtask

    task automatic sendGood(input logic [7:0] data);
        expQ.push_back(data);
        applyStimulus(1'b0, data, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic waitReady(input bit par, input string tag);
        int waited = 0;
        while ((par ? rxEmptyP : rxEmpty) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_ready"}, par ? rxEmptyP : rxEmpty, 0);
    endtask

    task automatic pulseRd(input bit par);
        if (par) rdP = 1'b1;
        else     rd  = 1'b1;
        @(negedge clk);
        rd  = 1'b0;
        rdP = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkHead(input string tag);
        logic [7:0] e;
        e = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
        checkOutput(tag, rData, e);
    endtask

    task automatic popHead(input string tag);
        waitReady(1'b0, tag);
        checkHead(tag);
        pulseRd(1'b0);
    endtask

    task automatic popP(input string tag, input logic [7:0] expected);
        waitReady(1'b1, tag);
        checkOutput(tag, rDataP, expected);
        pulseRd(1'b1);
    endtask

    task automatic pulseClr();
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] frames [6];
        frames = '{8'h55, 8'hAA, 8'hF0, 8'h0F, 8'h00, 8'hFF};

        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_empty", rxEmpty, 1);
        checkOutput("rst_full", rxFull, 0);
        checkOutput("rst_rdata", rData, 0);
        checkOutput("rst_ferr", frameErr, 0);
        checkOutput("rst_perr", parityErr, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_state", 32'(dut.receptor.current_state), 32'(ST_IDLE));

        $display("[TB] 8N1 frames");
        foreach (frames[i]) begin
            sendGood(frames[i]);
            popHead($sformatf("t1_frame%0d", i));
        end
        checkOutput("t1_ferr", frameErr, 0);
        checkOutput("t1_perr", parityErr, 0);
        checkOutput("t1_ovf", overflow, 0);
        checkOutput("t1_empty", rxEmpty, 1);

        $display("[TB] start glitch");
        setLine(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("t2_in_start", 32'(dut.receptor.current_state), 32'(ST_START));
        repeat (6) @(negedge clk);
        setLine(1'b0, 1'b1);
        repeat (60) @(negedge clk);
        checkOutput("t2_back_idle", 32'(dut.receptor.current_state), 32'(ST_IDLE));
        checkOutput("t2_empty", rxEmpty, 1);

        $display("[TB] framing error");
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_ferr_set", frameErr, 1);
        checkOutput("t3_empty", rxEmpty, 1);
        pulseClr();
        checkOutput("t3_ferr_clr", frameErr, 0);

        $display("[TB] even parity");
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        popP("t4_good_word", 8'h07);
        checkOutput("t4_perr_clean", parityErrP, 0);
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        popP("t4_bad_word", 8'h07);
        checkOutput("t4_perr_set", parityErrP, 1);
        checkOutput("t4_ferr", frameErrP, 0);

        $display("[TB] overflow");
        for (int i = 1; i <= 4; i++) sendGood(8'(i * 17));
        checkOutput("t5_full", rxFull, 1);
        checkOutput("t5_ovf_pre", overflow, 0);
        applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_ovf_set", overflow, 1);
        checkOutput("t5_full_kept", rxFull, 1);
        for (int i = 0; i < 4; i++) popHead($sformatf("t5_drain%0d", i));
        checkOutput("t5_empty", rxEmpty, 1);
        pulseClr();
        checkOutput("t5_ovf_clr", overflow, 0);

        for (int i = 1; i <= 4; i++) sendGood(8'h60 + 8'(i));
        expQ.push_back(8'h65);
        sendHead(1'b0, 8'h65, 1'b0, 1'b0);
        setLine(1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (dut.receptor.current_state == ST_STOP && dut.receptor.s == 15 && dut.baud.tick)
                found = 1'b1;
            else
                @(negedge clk);
        end
        checkOutput("t5_stop_tick_seen", found, 1);
        checkHead("t5_pop_on_stop");
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        repeat (BIT_CLKS + 48) @(negedge clk);
        checkOutput("t5_no_ovf", overflow, 0);
        checkOutput("t5_full_again", rxFull, 1);
        for (int i = 0; i < 4; i++) popHead($sformatf("t5_keep%0d", i));
        checkOutput("t5_empty_end", rxEmpty, 1);

        $display("[TB] reset mid-frame");
        sendGood(8'h99);
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_ferr_pre", frameErr, 1);
        setLine(1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        setLine(1'b0, 1'b1);
        repeat (3 * BIT_CLKS) @(negedge clk);
        checkOutput("t6_in_data", 32'(dut.receptor.current_state), 32'(ST_DATA));
        reset = 1'b0;
        setLine(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("t6_state", 32'(dut.receptor.current_state), 32'(ST_IDLE));
        checkOutput("t6_empty", rxEmpty, 1);
        checkOutput("t6_ferr", frameErr, 0);
        checkOutput("t6_rdata", rData, 0);
        expQ.delete();
        reset = 1'b1;
        repeat (20) @(negedge clk);
        sendGood(8'hA5);
        popHead("t6_clean_frame");
        checkOutput("t6_ferr_after", frameErr, 0);
        checkOutput("t6_ovf_after", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
